apb_commfifo_mc: RTL

Multi-channel, parametrised host/DUT communications FIFO on an APB3 slave port. It provides NCH independent channel pairs. Each pair has a host-to-DUT (H2D) FIFO, popped by APB reads, and a DUT-to-host (D2H) FIFO, pushed by APB writes. Each FIFO has a configurable data width and depth, and exposes fill levels, sticky overflow/underflow flags and threshold interrupts. It sits between the simulated core's APB bus and the testbench host ports.

---
 rtl/apb_commfifo_mc_if.sv | 17 +
 rtl/apb_commfifo_mc.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/apb_commfifo_mc_if.sv
// APB3 slave bundle for apb_commfifo_mc: the core drives the master side and the FIFO block is the slave.
`timescale 1ns/1ps
interface apb_commfifo_mc_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [11:2] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_commfifo_mc.sv
// Multi-channel host/DUT comms FIFO pairs on an APB3 slave port.
// Define COMMFIFO_IRQ_EN to build the CTRL/IRQSTAT registers and the irq output.
`timescale 1ns/1ps
module apb_commfifo_mc #(
  parameter int BW     = 8,
  parameter int LGFLEN = 6,
  parameter int NCH    = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_commfifo_mc_if.slave  apb,
  input  logic [NCH-1:0]    h2d_host_write,
  input  logic [NCH*BW-1:0] h2d_host_data,
  output logic [NCH-1:0]    h2d_host_not_full,
  input  logic [NCH-1:0]    d2h_host_rd,
  output logic [NCH*BW-1:0] d2h_host_data,
  output logic [NCH-1:0]    d2h_host_not_empty,
  output logic              irq
);
  localparam int                DEPTH    = 1 << LGFLEN;
  localparam int                LW       = LGFLEN + 1;
  localparam logic [LGFLEN-1:0] PTR_ONE  = LGFLEN'(1);
  localparam logic [LW-1:0]     LVL_ONE  = LW'(1);
  localparam logic [LW-1:0]     LVL_FULL = LW'(DEPTH);

  typedef struct packed {
    logic [LGFLEN-1:0] wp;
    logic [LGFLEN-1:0] rp;
    logic [LW-1:0]     lvl;
  } fifo_t;

  function automatic fifo_t fifo_next(fifo_t f, logic push, logic pop);
    fifo_t n;
    n = f;
    if (push) n.wp = f.wp + PTR_ONE;
    if (pop)  n.rp = f.rp + PTR_ONE;
    if (push && !pop)      n.lvl = f.lvl + LVL_ONE;
    else if (pop && !push) n.lvl = f.lvl - LVL_ONE;
    return n;
  endfunction

  // Address decode: channel in PADDR[7:4], register in PADDR[3:2].
  logic       access, mapped, rd_acc, wr_acc;
  logic [3:0] ch;
  logic [1:0] off;
  assign access      = apb.PSEL & apb.PENABLE;
  assign ch          = apb.PADDR[7:4];
  assign off         = apb.PADDR[3:2];
  assign mapped      = (apb.PADDR[11:8] == 4'd0) && (int'(ch) < NCH);
  assign rd_acc      = access & mapped & ~apb.PWRITE;
  assign wr_acc      = access & mapped & apb.PWRITE;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access & ~mapped;

  logic unused_pwdata;
  assign unused_pwdata = ^apb.PWDATA;

  logic [BW-1:0]  h2d_mem [NCH][DEPTH];
  logic [BW-1:0]  d2h_mem [NCH][DEPTH];
  fifo_t          h2d_st [NCH];
  fifo_t          d2h_st [NCH];
  logic [NCH-1:0] h2d_ovf, d2h_ovf, unf;
  logic [NCH-1:0] h2d_empty, h2d_full, d2h_empty, d2h_full;
  logic [NCH-1:0] h2d_push, h2d_pop, d2h_push, d2h_pop;
  logic [NCH-1:0] h2d_ovf_set, d2h_ovf_set, unf_set, stat_wr;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic data_rd, data_wr;
    assign data_rd        = rd_acc & (int'(ch) == c) & (off == 2'd0);
    assign data_wr        = wr_acc & (int'(ch) == c) & (off == 2'd0);
    assign stat_wr[c]     = wr_acc & (int'(ch) == c) & (off == 2'd1);
    assign h2d_empty[c]   = (h2d_st[c].lvl == '0);
    assign h2d_full[c]    = (h2d_st[c].lvl == LVL_FULL);
    assign d2h_empty[c]   = (d2h_st[c].lvl == '0);
    assign d2h_full[c]    = (d2h_st[c].lvl == LVL_FULL);
    // A pop frees the slot in the same edge, so a full FIFO still accepts a push alongside it.
    assign h2d_pop[c]     = data_rd & ~h2d_empty[c];
    assign h2d_push[c]    = h2d_host_write[c] & (~h2d_full[c] | h2d_pop[c]);
    assign h2d_ovf_set[c] = h2d_host_write[c] & h2d_full[c] & ~h2d_pop[c];
    assign unf_set[c]     = data_rd & h2d_empty[c];
    assign d2h_pop[c]     = d2h_host_rd[c] & ~d2h_empty[c];
    assign d2h_push[c]    = data_wr & (~d2h_full[c] | d2h_pop[c]);
    assign d2h_ovf_set[c] = data_wr & d2h_full[c] & ~d2h_pop[c];
    assign h2d_host_not_full[c]    = ~h2d_full[c];
    assign d2h_host_not_empty[c]   = ~d2h_empty[c];
    assign d2h_host_data[c*BW +: BW] = d2h_empty[c] ? '0 : d2h_mem[c][d2h_st[c].rp];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int c = 0; c < NCH; c++) begin
        h2d_st[c] <= '0;
        d2h_st[c] <= '0;
      end
      h2d_ovf <= '0;
      d2h_ovf <= '0;
      unf     <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        h2d_st[c] <= fifo_next(h2d_st[c], h2d_push[c], h2d_pop[c]);
        d2h_st[c] <= fifo_next(d2h_st[c], d2h_push[c], d2h_pop[c]);
      end
      // Set wins over a same-cycle W1C clear.
      h2d_ovf <= h2d_ovf_set | (h2d_ovf & ~(stat_wr & {NCH{apb.PWDATA[2]}}));
      d2h_ovf <= d2h_ovf_set | (d2h_ovf & ~(stat_wr & {NCH{apb.PWDATA[3]}}));
      unf     <= unf_set     | (unf     & ~(stat_wr & {NCH{apb.PWDATA[4]}}));
    end
  end

  // NOTE: storage arrays are not reset; outputs are gated by level, so stale entries never escape.
  always_ff @(posedge PCLK) begin
    for (int c = 0; c < NCH; c++) begin
      if (h2d_push[c]) h2d_mem[c][h2d_st[c].wp] <= h2d_host_data[c*BW +: BW];
      if (d2h_push[c]) d2h_mem[c][d2h_st[c].wp] <= apb.PWDATA[BW-1:0];
    end
  end

`ifdef COMMFIFO_IRQ_EN
  logic [NCH-1:0] rxie, txie, rx_pend, tx_pend;
  logic [7:0]     rxth [NCH];
  logic [7:0]     txth [NCH];
  logic           irq_q;

  for (genvar c = 0; c < NCH; c++) begin : g_pend
    assign rx_pend[c] = rxie[c] & (8'(h2d_st[c].lvl) >= rxth[c]) & (rxth[c] != 8'd0);
    assign tx_pend[c] = txie[c] & (8'(d2h_st[c].lvl) <= txth[c]);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rxie  <= '0;
      txie  <= '0;
      irq_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        rxth[c] <= '0;
        txth[c] <= '0;
      end
    end else begin
      irq_q <= |(rx_pend | tx_pend);
      for (int c = 0; c < NCH; c++) begin
        if (wr_acc && off == 2'd2 && int'(ch) == c) begin
          rxie[c] <= apb.PWDATA[0];
          txie[c] <= apb.PWDATA[1];
          rxth[c] <= apb.PWDATA[15:8];
          txth[c] <= apb.PWDATA[23:16];
        end
      end
    end
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  logic [31:0] rd_val;
  always_comb begin
    // NOTE: default assigned first so every path drives rd_val and no latch is inferred.
    rd_val = '0;
    for (int c = 0; c < NCH; c++) begin
      if (int'(ch) == c) begin
        case (off)
          2'd0: if (!h2d_empty[c]) rd_val = 32'(h2d_mem[c][h2d_st[c].rp]);
          2'd1: rd_val = {8'd0, 8'(d2h_st[c].lvl), 8'(h2d_st[c].lvl), 3'd0,
                          unf[c], d2h_ovf[c], h2d_ovf[c], ~d2h_full[c], ~h2d_empty[c]};
`ifdef COMMFIFO_IRQ_EN
          2'd2: rd_val = {8'd0, txth[c], rxth[c], 6'd0, txie[c], rxie[c]};
          2'd3: rd_val = {30'd0, tx_pend[c], rx_pend[c]};
`endif
          default: rd_val = '0;
        endcase
      end
    end
  end
  assign apb.PRDATA = rd_acc ? rd_val : '0;
endmodule
